// File: rtl/tmr_fault_manager.sv
// Fault manager downstream of the TMR voter: per-core statistics, persistence detection,
// resync sequencing and permanent-failure marking. Optional irq under TMR_FAULT_MGR_IRQ_EN.
module tmr_fault_manager #(
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned PERSIST_CYCLES = 4,
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_valid,
    input  logic                   disagreement,
    input  logic [2:0]             fault_flags,
    input  logic                   clear_counts,
    output logic [2:0]             core_rst_n,
    output logic                   resync_busy,
    output logic [1:0]             resync_target,
    output logic [3*CNT_WIDTH-1:0] fault_cnt,
    output logic                   multi_fault,
    output logic [CNT_WIDTH-1:0]   multi_fault_cnt,
    output logic [2:0]             core_failed,
    output logic                   irq
);

    localparam logic [7:0]  PersistVal = 8'(PERSIST_CYCLES);
    localparam logic [15:0] ResetLast  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] SettleLast = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  MaxRetry   = 4'(MAX_RETRY);
    localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        StMonitor,
        StResetCore,
        StSettle
    } state_e;

    state_e r_state, w_state_d;
    logic [1:0]           r_target, w_target_d;
    logic [15:0]          r_timer, w_timer_d;
    logic [CNT_WIDTH-1:0] r_fault_cnt [3];
    logic [CNT_WIDTH-1:0] r_mf_cnt;
    logic [7:0]           r_consec [3];
    logic [3:0]           r_retry [3];
    logic [2:0]           r_failed;
    logic [2:0]           r_core_rst_n;
    logic                 r_mf;

    logic [2:0] w_mask;
    logic [2:0] w_eff;
    logic       w_multi;
    logic [2:0] w_persist;
    logic [2:0] w_sel;
    logic [1:0] w_pick_idx;
    logic [2:0] w_at_max;
    logic       w_start;
    logic [2:0] w_fail_set;
    logic [2:0] w_retry_inc;

    // Resync target and failed cores are excluded from every statistic.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 3; i++) begin
            w_mask[i] = r_failed[i] | ((r_state != StMonitor) && (r_target == 2'(i)));
        end
    end

    assign w_eff   = (sample_valid & disagreement) ? (fault_flags & ~w_mask) : 3'b000;
    assign w_multi = (w_eff[2] & w_eff[1]) | (w_eff[2] & w_eff[0]) | (w_eff[1] & w_eff[0]);

    // >= keeps a core that kept faulting while waiting eligible once the FSM is free.
    always_comb begin
        w_persist = '0;
        w_at_max  = '0;
        for (int i = 0; i < 3; i++) begin
            w_persist[i] = (r_consec[i] >= PersistVal) & ~r_failed[i];
            w_at_max[i]  = (r_retry[i] == MaxRetry);
        end
    end

    assign w_sel[2]   = w_persist[2];
    assign w_sel[1]   = w_persist[1] & ~w_persist[2];
    assign w_sel[0]   = w_persist[0] & ~w_persist[2] & ~w_persist[1];
    assign w_pick_idx = w_sel[2] ? 2'd2 : (w_sel[1] ? 2'd1 : 2'd0);

    always_comb begin
        w_state_d   = r_state;
        w_target_d  = r_target;
        w_timer_d   = r_timer;
        w_start     = 1'b0;
        w_fail_set  = 3'b000;
        w_retry_inc = 3'b000;
        unique case (r_state)
            StMonitor: begin
                w_target_d = 2'd3;
                if (|w_sel) begin
                    if (|(w_sel & w_at_max)) begin
                        w_fail_set = w_sel;
                    end else begin
                        w_state_d  = StResetCore;
                        w_target_d = w_pick_idx;
                        w_timer_d  = '0;
                        w_start    = 1'b1;
                    end
                end
            end
            StResetCore: begin
                if (r_timer == ResetLast) begin
                    w_state_d = StSettle;
                    w_timer_d = '0;
                end else begin
                    w_timer_d = r_timer + 16'd1;
                end
            end
            StSettle: begin
                if (r_timer == SettleLast) begin
                    w_state_d  = StMonitor;
                    w_target_d = 2'd3;
                    w_timer_d  = '0;
                    for (int i = 0; i < 3; i++) begin
                        w_retry_inc[i] = (r_target == 2'(i));
                    end
                end else begin
                    w_timer_d = r_timer + 16'd1;
                end
            end
            default: begin
                w_state_d  = StMonitor;
                w_target_d = 2'd3;
                w_timer_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StMonitor;
            r_target     <= 2'd3;
            r_timer      <= '0;
            r_core_rst_n <= 3'b111;
        end else begin
            r_state      <= w_state_d;
            r_target     <= w_target_d;
            r_timer      <= w_timer_d;
            r_core_rst_n <= (w_state_d == StResetCore) ? ~(3'b001 << w_target_d) : 3'b111;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_fault_cnt[i] <= '0;
                r_consec[i]    <= '0;
                r_retry[i]     <= '0;
            end
            r_failed <= '0;
            r_mf     <= 1'b0;
            r_mf_cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (clear_counts) begin
                    r_fault_cnt[i] <= '0;
                end else if (w_eff[i] && (r_fault_cnt[i] != CntMax)) begin
                    r_fault_cnt[i] <= r_fault_cnt[i] + 1'b1;
                end

                if (w_start && w_sel[i]) begin
                    r_consec[i] <= '0;
                end else if (sample_valid) begin
                    if (!w_eff[i]) begin
                        r_consec[i] <= '0;
                    end else if (r_consec[i] != 8'hFF) begin
                        r_consec[i] <= r_consec[i] + 8'd1;
                    end
                end

                if (clear_counts) begin
                    r_retry[i] <= '0;
                end else if (w_retry_inc[i] && (r_retry[i] != 4'hF)) begin
                    r_retry[i] <= r_retry[i] + 4'd1;
                end
            end

            if (clear_counts) begin
                r_failed <= '0;
            end else begin
                r_failed <= r_failed | w_fail_set;
            end

            r_mf <= w_multi;
            if (clear_counts) begin
                r_mf_cnt <= '0;
            end else if (w_multi && (r_mf_cnt != CntMax)) begin
                r_mf_cnt <= r_mf_cnt + 1'b1;
            end
        end
    end

`ifdef TMR_FAULT_MGR_IRQ_EN
    logic r_irq;
    logic w_irq_set;

    assign w_irq_set = w_start | (|w_fail_set) | w_multi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (clear_counts) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    assign core_rst_n      = r_core_rst_n;
    assign resync_busy     = (r_state != StMonitor);
    assign resync_target   = r_target;
    assign fault_cnt       = {r_fault_cnt[2], r_fault_cnt[1], r_fault_cnt[0]};
    assign multi_fault     = r_mf;
    assign multi_fault_cnt = r_mf_cnt;
    assign core_failed     = r_failed;

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Scoreboard bench for tmr_fault_manager: expectations are queued with the stimulus that
// causes them and compared on the falling edge after the sampling clock edge.
module tb_tmr_fault_manager;

    localparam int CW = 16;

    localparam int SelRst    = 0;
    localparam int SelBusy   = 1;
    localparam int SelTarget = 2;
    localparam int SelCntA   = 3;
    localparam int SelCntB   = 4;
    localparam int SelCntC   = 5;
    localparam int SelMf     = 6;
    localparam int SelMfCnt  = 7;
    localparam int SelFailed = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sample_valid = 1'b0;
    logic            disagreement = 1'b0;
    logic [2:0]      fault_flags = 3'b000;
    logic            clear_counts = 1'b0;
    logic [2:0]      core_rst_n;
    logic            resync_busy;
    logic [1:0]      resync_target;
    logic [3*CW-1:0] fault_cnt;
    logic            multi_fault;
    logic [CW-1:0]   multi_fault_cnt;
    logic [2:0]      core_failed;
    logic            irq;

    tmr_fault_manager dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_valid   (sample_valid),
        .disagreement   (disagreement),
        .fault_flags    (fault_flags),
        .clear_counts   (clear_counts),
        .core_rst_n     (core_rst_n),
        .resync_busy    (resync_busy),
        .resync_target  (resync_target),
        .fault_cnt      (fault_cnt),
        .multi_fault    (multi_fault),
        .multi_fault_cnt(multi_fault_cnt),
        .core_failed    (core_failed),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        int            sel;
        logic [CW-1:0] exp;
        string         tag;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] observe(input int sel);
        case (sel)
            SelRst:    return CW'(core_rst_n);
            SelBusy:   return CW'(resync_busy);
            SelTarget: return CW'(resync_target);
            SelCntA:   return fault_cnt[3*CW-1:2*CW];
            SelCntB:   return fault_cnt[2*CW-1:CW];
            SelCntC:   return fault_cnt[CW-1:0];
            SelMf:     return CW'(multi_fault);
            SelMfCnt:  return multi_fault_cnt;
            SelFailed: return CW'(core_failed);
            default:   return '0;
        endcase
    endfunction

    task automatic expect_nxt(input int sel, input logic [CW-1:0] v, input string tag);
        sb_q.push_back('{cyc + 1, sel, v, tag});
    endtask

    // Drive one cycle of inputs, then compare every expectation due after this edge.
    task automatic step(input logic sv, input logic dis, input logic [2:0] fl, input logic clr);
        sample_valid = sv;
        disagreement = dis;
        fault_flags  = fl;
        clear_counts = clr;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                check_eq(sb_q[i].tag, observe(sb_q[i].sel), sb_q[i].exp);
                sb_q.delete(i);
            end
        end
    endtask

    task automatic persist(input logic [2:0] fl);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, fl, 1'b0);
    endtask

    // Full resync of core t starting from the MONITOR decision edge.
    task automatic run_resync(input int t, input logic [CW-1:0] tgt_cnt, input int clr_at,
                              input bit drive_masked);
        logic [2:0] low;
        logic [2:0] oh;
        oh  = 3'b001 << t;
        low = ~oh;
        for (int j = 0; j < 16; j++) begin
            expect_nxt(SelRst, CW'(low), "rst_low");
            expect_nxt(SelBusy, 1, "busy_reset");
            expect_nxt(SelTarget, CW'(t), "target_reset");
            if (j == clr_at) begin
                expect_nxt(SelCntA, 0, "clr_cnt_a");
                expect_nxt(SelCntB, 0, "clr_cnt_b");
                expect_nxt(SelCntC, 0, "clr_cnt_c");
                expect_nxt(SelMfCnt, 0, "clr_mf_cnt");
            end
            step(1'b0, 1'b0, 3'b000, j == clr_at);
        end
        for (int j = 0; j < 64; j++) begin
            expect_nxt(SelRst, 3'b111, "rst_settle");
            expect_nxt(SelBusy, 1, "busy_settle");
            expect_nxt(5 - t, tgt_cnt, "masked_cnt");
            if (drive_masked) step(1'b1, 1'b1, oh, 1'b0);
            else              step(1'b0, 1'b0, 3'b000, 1'b0);
        end
        expect_nxt(SelBusy, 0, "busy_done");
        expect_nxt(SelTarget, 3, "target_none");
        step(1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    initial begin
        logic exp_irq;

        // Reset values
        @(negedge clk);
        check_eq("rst_core_rst_n", CW'(core_rst_n), 3'b111);
        check_eq("rst_busy", CW'(resync_busy), 0);
        check_eq("rst_target", CW'(resync_target), 3);
        check_eq("rst_fault_cnt", fault_cnt[CW-1:0] | fault_cnt[2*CW-1:CW] | fault_cnt[3*CW-1:2*CW], 0);
        check_eq("rst_mf", CW'(multi_fault), 0);
        check_eq("rst_failed", CW'(core_failed), 0);
        check_eq("rst_irq", CW'(irq), 0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 3'b000, 1'b0);

        // Single transient on B
        expect_nxt(SelCntB, 1, "transient_cnt_b");
        step(1'b1, 1'b1, 3'b010, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expect_nxt(SelRst, 3'b111, "transient_no_rst");
            expect_nxt(SelBusy, 0, "transient_idle");
            step(1'b0, 1'b0, 3'b000, 1'b0);
        end

        // Persistent fault on A, then two more resyncs
        for (int r = 0; r < 3; r++) begin
            persist(3'b100);
            run_resync(2, CW'(4 * (r + 1)), -1, 1'b1);
        end

        // Fourth persistence on A: retries exhausted
        persist(3'b100);
        expect_nxt(SelCntA, 16, "exhaust_cnt_a");
        expect_nxt(SelFailed, 3'b100, "core_failed_a");
        expect_nxt(SelBusy, 0, "exhaust_no_busy");
        expect_nxt(SelRst, 3'b111, "exhaust_no_rst");
        step(1'b0, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            expect_nxt(SelCntA, 16, "failed_cnt_frozen");
            expect_nxt(SelRst, 3'b111, "failed_no_rst");
            step(1'b1, 1'b1, 3'b100, 1'b0);
        end

        // clear_counts, then a multi-fault sample
        expect_nxt(SelCntA, 0, "clear_cnt_a");
        expect_nxt(SelCntB, 0, "clear_cnt_b");
        expect_nxt(SelFailed, 0, "clear_failed");
        step(1'b0, 1'b0, 3'b000, 1'b1);
        step(1'b1, 1'b0, 3'b000, 1'b0);
        expect_nxt(SelMf, 1, "mf_pulse");
        expect_nxt(SelMfCnt, 1, "mf_cnt");
        expect_nxt(SelCntB, 1, "mf_cnt_b");
        expect_nxt(SelCntC, 1, "mf_cnt_c");
        expect_nxt(SelCntA, 0, "mf_cnt_a");
        step(1'b1, 1'b1, 3'b011, 1'b0);
        expect_nxt(SelMf, 0, "mf_one_cycle");
        expect_nxt(SelMfCnt, 1, "mf_cnt_hold");
        step(1'b0, 1'b0, 3'b000, 1'b0);

        // Simultaneous B and C persistence; clear mid-resync of B
        step(1'b1, 1'b0, 3'b000, 1'b0);
        persist(3'b011);
        expect_nxt(SelCntB, 5, "bc_cnt_b");
        expect_nxt(SelCntC, 5, "bc_cnt_c");
        expect_nxt(SelMfCnt, 5, "bc_mf_cnt");
        run_resync(1, 0, 5, 1'b0);
        expect_nxt(SelTarget, 0, "c_after_b_target");
        expect_nxt(SelRst, 3'b110, "c_after_b_rst");
        expect_nxt(SelBusy, 1, "c_after_b_busy");
        step(1'b0, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_nxt(SelRst, 3'b110, "c_rst_low");
            step(1'b0, 1'b0, 3'b000, 1'b0);
        end

`ifdef TMR_FAULT_MGR_IRQ_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif
        check_eq("irq_level", CW'(irq), CW'(exp_irq));

        // Async reset in RESET_CORE, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_core_rst_n", CW'(core_rst_n), 3'b111);
        check_eq("async_busy", CW'(resync_busy), 0);
        check_eq("async_target", CW'(resync_target), 3);
        check_eq("async_cnt_c", fault_cnt[CW-1:0], 0);
        check_eq("async_mf", CW'(multi_fault), 0);
        check_eq("async_failed", CW'(core_failed), 0);
        check_eq("async_irq", CW'(irq), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 3'b000, 1'b0);

        check_eq("sb_drained", CW'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
